// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the funct3 legality test used at request accept.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERR    = 3'd1,
    ST_LD     = 3'd2,
    ST_STW    = 3'd3,
    ST_RMW_RD = 3'd4,
    ST_RMW_WR = 3'd5,
    ST_RESP   = 3'd6
  } lsu_state_e;

  // Stores only exist as B/H/W; loads additionally allow the unsigned B/H forms.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    if (is_store) begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      ok = !((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension, store lane merge into a
// previously read word, and the alignment check for a funct3/offset pair.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] extended_load,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword out of the memory word.
  always_comb begin
    byte_s = 8'd0;
    case (addr)
      2'd0:    byte_s = word_in[7:0];
      2'd1:    byte_s = word_in[15:8];
      2'd2:    byte_s = word_in[23:16];
      2'd3:    byte_s = word_in[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr[1]) begin
      half_s = word_in[31:16];
    end else begin
      half_s = word_in[15:0];
    end
  end

  // Sign/zero extension by access type.
  always_comb begin
    extended_load = 32'd0;
    case (funct3)
      F3_B:    extended_load = {{24{byte_s[7]}}, byte_s};
      F3_H:    extended_load = {{16{half_s[15]}}, half_s};
      F3_W:    extended_load = word_in;
      F3_BU:   extended_load = {24'd0, byte_s};
      F3_HU:   extended_load = {16'd0, half_s};
      default: extended_load = 32'd0;
    endcase
  end

  // Replace the target lane(s) of the read word with right-aligned store data.
  always_comb begin
    merged_word = word_in;
    case (funct3)
      F3_B: begin
        case (addr)
          2'd0:    merged_word[7:0]   = store_data[7:0];
          2'd1:    merged_word[15:8]  = store_data[7:0];
          2'd2:    merged_word[23:16] = store_data[7:0];
          2'd3:    merged_word[31:24] = store_data[7:0];
          default: merged_word = word_in;
        endcase
      end
      F3_H: begin
        if (addr[1]) begin
          merged_word[31:16] = store_data[15:0];
        end else begin
          merged_word[15:0] = store_data[15:0];
        end
      end
      F3_W:    merged_word = store_data;
      default: merged_word = word_in;
    endcase
  end

  // Halfword forms end in 01, word in 10; illegal codes are rejected elsewhere.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr != 2'd0);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only data memory. Sub-word stores run
// as read-modify-write; all outputs are registered and follow the next state.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        idle_s;
  logic [2:0]  la_f3_s;
  logic [1:0]  la_addr_s;
  logic [31:0] ext_load_s, merged_s;
  logic        misaligned_s;

  // In IDLE the aligner checks the incoming request; otherwise it works on the held one.
  assign idle_s    = (state_q == ST_IDLE);
  assign la_f3_s   = idle_s ? req_funct3 : f3_q;
  assign la_addr_s = idle_s ? req_addr[1:0] : addr_lo_q;

  lsu_lane_align u_lane_align (
    .funct3        (la_f3_s),
    .addr          (la_addr_s),
    .word_in       (mem_rdata),
    .store_data    (wdata_q),
    .extended_load (ext_load_s),
    .merged_word   (merged_s),
    .misaligned    (misaligned_s)
  );

  // Next-state and next-output logic; the RMW merge register is mem_wdata_q itself.
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d       = req_funct3;
          addr_lo_d  = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[31:2], 2'b00};
          if (!funct3_legal(req_write, req_funct3) || misaligned_s) begin
            state_d = ST_ERR;
          end else if (!req_write) begin
            state_d    = ST_LD;
            mem_read_d = 1'b1;
          end else if (req_funct3 == F3_W) begin
            state_d     = ST_STW;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = ST_RMW_RD;
            mem_read_d = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_ERR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = 32'd0;
      end
      ST_LD: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = ext_load_s;
      end
      ST_STW, ST_RMW_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      ST_RMW_RD: begin
        state_d     = ST_RMW_WR;
        mem_write_d = 1'b1;
        mem_wdata_d = merged_s;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      f3_q         <= 3'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
